// File: rtl/app_pkg.sv
// Shared constants and types for the XGMII frame generator / checker.
package app_pkg;

    // XGMII control characters and fixed words
    localparam logic [7:0]  XGMII_IDLE    = 8'h07;
    localparam logic [7:0]  XGMII_START   = 8'hFB;
    localparam logic [7:0]  XGMII_TERM    = 8'hFD;
    localparam logic [63:0] IDLE_WORD     = {8{XGMII_IDLE}};
    localparam logic [63:0] PREAMBLE_WORD = 64'hD5555555555555FB;

    // Frame header fields, most significant byte goes first on the wire
    localparam logic [47:0] DEST_MAC  = 48'hFFFFFFFFFFFF;
    localparam logic [47:0] SRC_MAC   = 48'h001122334455;
    localparam logic [15:0] ETHERTYPE = 16'h88B5;

    // Longest frame the receiver accepts: k = 15 gives 128 data words
    localparam int MAX_DATA_WORDS = 128;

    // Bit-reverse helper, used to derive the LSB-first CRC polynomial
    function automatic logic [31:0] reflect32(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = v[31-i];
        return r;
    endfunction

    localparam logic [31:0] CRC_POLY      = 32'h04C11DB7;
    localparam logic [31:0] CRC_POLY_REFL = reflect32(CRC_POLY);
    localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;

    typedef enum logic [2:0] {TX_WAIT, TX_START, TX_DATA, TX_FCS, TX_GAP} tx_state_e;
    typedef enum logic [1:0] {RX_HUNT, RX_DATA, RX_CHECK} rx_state_e;

    // Data word W(idx+1) of a frame: header in the first three words, zero payload after
    function automatic logic [63:0] tx_data_word(input logic [7:0] idx, input logic [31:0] seq);
        case (idx)
            8'd0:    return {SRC_MAC[39:32], SRC_MAC[47:40],
                             DEST_MAC[7:0], DEST_MAC[15:8], DEST_MAC[23:16],
                             DEST_MAC[31:24], DEST_MAC[39:32], DEST_MAC[47:40]};
            8'd1:    return {seq[23:16], seq[31:24], ETHERTYPE[7:0], ETHERTYPE[15:8],
                             SRC_MAC[7:0], SRC_MAC[15:8], SRC_MAC[23:16], SRC_MAC[31:24]};
            8'd2:    return {48'h0, seq[7:0], seq[15:8]};
            default: return 64'h0;
        endcase
    endfunction

endpackage

// File: rtl/crc32_d64.sv
// Combinational next-state of the reflected Ethernet CRC-32 over one 64-bit word.
// Lane 0 is consumed first, each byte LSB first.
module crc32_d64
    import app_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [63:0] data,
    output logic [31:0] crc_out
);

    // Shift all 64 data bits through the CRC register in wire order
    always_comb begin
        crc_out = crc_in;
        // NOTE: blocking assignments here chain one bit step into the next within the
        // same evaluation; registers elsewhere use <= so every flop samples pre-edge values.
        for (int i = 0; i < 64; i++) begin
            crc_out = {1'b0, crc_out[31:1]} ^ ((crc_out[0] ^ data[i]) ? CRC_POLY_REFL : 32'h0);
        end
    end

endmodule

// File: rtl/app.sv
// XGMII test-frame transmitter plus loopback receiver/checker with LED status.
module app
    import app_pkg::*;
#(
    parameter int TX_START_DELAY = 16,
    parameter int IFG_WORDS      = 4
) (
    input  logic        xgmii_clk,
    input  logic        sys_rst,
    output logic [63:0] xgmii_txd,
    output logic [7:0]  xgmii_txc,
    input  logic [63:0] xgmii_rxd,
    input  logic [7:0]  xgmii_rxc,
    input  logic [3:0]  dipsw,
    output logic [7:0]  led
);

    // ---------------- transmitter ----------------
    tx_state_e   tx_state, tx_next;
    logic [31:0] tx_cnt;       // wait/gap length, or data word index
    logic [3:0]  tx_k;         // frame size latched at W0
    logic [31:0] tx_seq;
    logic [31:0] tx_crc, tx_crc_next;
    logic [63:0] tx_word;
    logic [7:0]  tx_last;

    assign tx_last = {1'b0, tx_k, 3'b111};   // 8(k+1) data words, zero based

    crc32_d64 u_tx_crc (.crc_in(tx_crc), .data(tx_word), .crc_out(tx_crc_next));

    // TX state register; reset drops straight back to idle output
    always_ff @(posedge xgmii_clk or negedge sys_rst) begin
        if (!sys_rst) tx_state <= TX_WAIT;
        else          tx_state <= tx_next;
    end

    // TX next state and XGMII output word
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        tx_next   = tx_state;
        xgmii_txd = IDLE_WORD;
        xgmii_txc = 8'hFF;
        tx_word   = tx_data_word(tx_cnt[7:0], tx_seq);
        case (tx_state)
            TX_WAIT:  if (tx_cnt == 32'(TX_START_DELAY - 1)) tx_next = TX_START;
            TX_START: begin
                xgmii_txd = PREAMBLE_WORD;
                xgmii_txc = 8'h01;
                tx_next   = TX_DATA;
            end
            TX_DATA: begin
                xgmii_txd = tx_word;
                xgmii_txc = 8'h00;
                if (tx_cnt[7:0] == tx_last) tx_next = TX_FCS;
            end
            TX_FCS: begin
                xgmii_txd = {{3{XGMII_IDLE}}, XGMII_TERM, ~tx_crc};
                xgmii_txc = 8'hF0;
                tx_next   = (IFG_WORDS == 0) ? TX_START : TX_GAP;
            end
            TX_GAP:   if (tx_cnt == 32'(IFG_WORDS - 1)) tx_next = TX_START;
            default:  tx_next = TX_WAIT;
        endcase
    end

    // TX datapath: per-state counter, frame size, running CRC and sequence number
    always_ff @(posedge xgmii_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            tx_cnt <= '0;
            tx_k   <= '0;
            tx_seq <= '0;
            tx_crc <= CRC_INIT;
        end else begin
            tx_cnt <= (tx_next != tx_state) ? 32'd0 : tx_cnt + 32'd1;
            case (tx_state)
                TX_START: begin
                    tx_k   <= dipsw;
                    tx_crc <= CRC_INIT;
                end
                TX_DATA:  tx_crc <= tx_crc_next;
                TX_FCS:   tx_seq <= tx_seq + 32'd1;
                default:  ;
            endcase
        end
    end

    // ---------------- receiver ----------------
    rx_state_e   rx_state, rx_next;
    logic [7:0]  rx_idx;       // data words received in the current frame
    logic [31:0] rx_crc, rx_crc_next;
    logic [31:0] rx_seq, rx_exp, rx_fcs, good_cnt;
    logic [15:0] rx_type;
    logic        rx_exp_valid, err_flag;
    logic        rx_start, rx_term, rx_abort, frame_ok;

    assign rx_start = (xgmii_rxc == 8'h01) && (xgmii_rxd[7:0] == XGMII_START);
    assign rx_term  = (xgmii_rxc == 8'hF0) && (xgmii_rxd[39:32] == XGMII_TERM);
    assign frame_ok = (rx_idx >= 8'd3) && (rx_type == ETHERTYPE) && (rx_fcs == ~rx_crc)
                   && (!rx_exp_valid || rx_seq == rx_exp);

    crc32_d64 u_rx_crc (.crc_in(rx_crc), .data(xgmii_rxd), .crc_out(rx_crc_next));

    // RX state register; reset returns the receiver to hunt
    always_ff @(posedge xgmii_clk or negedge sys_rst) begin
        if (!sys_rst) rx_state <= RX_HUNT;
        else          rx_state <= rx_next;
    end

    // RX next state; any control word other than a terminate aborts the frame
    always_comb begin
        rx_next  = rx_state;
        rx_abort = 1'b0;
        case (rx_state)
            RX_HUNT:  if (rx_start) rx_next = RX_DATA;
            RX_DATA: begin
                if (rx_term) begin
                    rx_next = RX_CHECK;
                end else if (xgmii_rxc != 8'h00 || rx_idx == 8'(MAX_DATA_WORDS)) begin
                    rx_next  = RX_HUNT;
                    rx_abort = 1'b1;
                end
            end
            RX_CHECK: rx_next = rx_start ? RX_DATA : RX_HUNT;
            default:  rx_next = RX_HUNT;
        endcase
    end

    // RX datapath: header capture, CRC, verdict, counters and registered LEDs
    always_ff @(posedge xgmii_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            rx_idx       <= '0;
            rx_crc       <= CRC_INIT;
            rx_seq       <= '0;
            rx_type      <= '0;
            rx_fcs       <= '0;
            rx_exp       <= '0;
            rx_exp_valid <= 1'b0;
            good_cnt     <= '0;
            err_flag     <= 1'b0;
            led          <= '0;
        end else begin
            led <= {err_flag, good_cnt[6:0]};
            if (rx_state != RX_DATA && rx_start) begin
                rx_idx <= '0;
                rx_crc <= CRC_INIT;
            end
            if (rx_state == RX_DATA && rx_next == RX_DATA) begin
                rx_crc <= rx_crc_next;
                rx_idx <= rx_idx + 8'd1;
                if (rx_idx == 8'd1) begin
                    rx_type        <= {xgmii_rxd[39:32], xgmii_rxd[47:40]};
                    rx_seq[31:16]  <= {xgmii_rxd[55:48], xgmii_rxd[63:56]};
                end
                if (rx_idx == 8'd2) rx_seq[15:0] <= {xgmii_rxd[7:0], xgmii_rxd[15:8]};
            end
            if (rx_state == RX_DATA && rx_term) rx_fcs <= xgmii_rxd[31:0];
            if (rx_abort) err_flag <= 1'b1;
            if (rx_state == RX_CHECK) begin
                if (frame_ok) good_cnt <= good_cnt + 32'd1;
                else          err_flag <= 1'b1;
                rx_exp       <= rx_seq + 32'd1;
                rx_exp_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_app.sv
// Self-checking bench for app: XGMII loopback with a byte-level frame/CRC model.
module tb_app;

    localparam int START_DLY = 16;
    localparam int IFG       = 4;
    localparam logic [63:0] IDLE64 = 64'h0707070707070707;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [63:0] txd, rxd;
    logic [7:0]  txc, rxc, led;
    logic [3:0]  dipsw = 4'h0;

    always #5 clk = ~clk;

    app #(.TX_START_DELAY(START_DLY), .IFG_WORDS(IFG)) dut (
        .xgmii_clk(clk), .sys_rst(rst),
        .xgmii_txd(txd), .xgmii_txc(txc),
        .xgmii_rxd(rxd), .xgmii_rxc(rxc),
        .dipsw(dipsw), .led(led)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [63:0] d;
        logic [7:0]  c;
        int          frame;   // -1 for idle words
        int          word;    // 0 = W0, 1.. = data words
        bit          last;    // FCS word
        logic [31:0] seq;
    } word_t;

    typedef struct {
        int         due;
        logic [7:0] led;
    } upd_t;

    word_t       q[$];
    upd_t        pend[$];
    word_t       w;
    bit          started, need_gap;
    int          frame_no, frames_done, cyc;
    logic [31:0] m_seq, m_good, m_exp;
    bit          m_err, m_exp_valid;
    logic [7:0]  m_led;

    int flip_frame = -1, flip_word = 4, flip_bit = 0, drop_frame = -1;
    bit inj_drop = 1'b0, inj_flip = 1'b0;

    // Loopback wire with fault injection
    always_comb begin
        rxd = txd;
        rxc = txc;
        if (inj_drop) begin
            rxd = IDLE64;
            rxc = 8'hFF;
        end else if (inj_flip) begin
            rxd = txd ^ (64'h1 << flip_bit);
        end
    end

    function automatic logic [31:0] crc32_bytes(input logic [7:0] b[$]);
        logic [31:0] c = 32'hFFFFFFFF;
        foreach (b[i]) begin
            c = c ^ {24'h0, b[i]};
            for (int j = 0; j < 8; j++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return ~c;
    endfunction

    function automatic void push_idles(input int n);
        word_t iw;
        iw = '{d: IDLE64, c: 8'hFF, frame: -1, word: 0, last: 1'b0, seq: 32'h0};
        for (int i = 0; i < n; i++) q.push_back(iw);
    endfunction

    function automatic void build_frame(input int k, input logic [31:0] seq, input int fr);
        logic [7:0] b[$];
        word_t      fw;
        logic [31:0] fcs;
        int         nbytes = 64 * (k + 1);
        for (int i = 0; i < 6; i++) b.push_back(8'hFF);
        for (int i = 0; i < 6; i++) b.push_back(8'(8'h00 + 8'h11 * i));
        b.push_back(8'h88); b.push_back(8'hB5);
        b.push_back(seq[31:24]); b.push_back(seq[23:16]);
        b.push_back(seq[15:8]);  b.push_back(seq[7:0]);
        while (b.size() < nbytes) b.push_back(8'h00);
        fw = '{d: 64'hD5555555555555FB, c: 8'h01, frame: fr, word: 0, last: 1'b0, seq: seq};
        q.push_back(fw);
        for (int wi = 0; wi < nbytes / 8; wi++) begin
            for (int n = 0; n < 8; n++) fw.d[8*n +: 8] = b[8*wi + n];
            fw.c    = 8'h00;
            fw.word = wi + 1;
            q.push_back(fw);
        end
        fcs     = crc32_bytes(b);
        fw.d    = {24'h070707, 8'hFD, fcs};
        fw.c    = 8'hF0;
        fw.word = nbytes / 8 + 1;
        fw.last = 1'b1;
        q.push_back(fw);
    endfunction

    function automatic void model_reset();
        q.delete();
        pend.delete();
        started = 0; need_gap = 0; frame_no = 0; frames_done = 0; cyc = 0;
        m_seq = 0; m_good = 0; m_exp = 0; m_err = 0; m_exp_valid = 0; m_led = 8'h00;
    endfunction

    function automatic void refill();
        if (!started) begin
            push_idles(START_DLY);
            started = 1;
        end else if (need_gap) begin
            push_idles(IFG);
            need_gap = 0;
        end else begin
            build_frame(int'(dipsw), m_seq, frame_no);
            m_seq++;
            frame_no++;
            need_gap = 1;
        end
    endfunction

    // Receiver verdict for a frame whose terminate word is on the wire this cycle
    function automatic void model_rx(input word_t fw);
        bit good;
        upd_t u;
        frames_done++;
        if (fw.frame == drop_frame) return;
        good = (fw.frame != flip_frame) && (!m_exp_valid || fw.seq == m_exp);
        if (good) m_good++;
        else      m_err = 1;
        m_exp       = fw.seq + 1;
        m_exp_valid = 1;
        u.due = cyc + 3;
        u.led = {m_err, m_good[6:0]};
        pend.push_back(u);
    endfunction

    // Single compare process: every cycle against the model
    always @(negedge clk) begin
        if (!rst) begin
            check("reset_txd", txd, IDLE64);
            check("reset_txc", txc, 8'hFF);
            check("reset_led", led, 8'h00);
            model_reset();
            inj_drop = 1'b0;
            inj_flip = 1'b0;
        end else begin
            if (q.size() == 0) refill();
            w = q.pop_front();
            inj_drop = (w.frame >= 0) && (w.frame == drop_frame);
            inj_flip = (w.frame >= 0) && (w.frame == flip_frame) && (w.word == flip_word);
            check("txd", txd, w.d);
            check("txc", txc, w.c);
            if (w.last) model_rx(w);
            while (pend.size() > 0 && pend[0].due <= cyc) begin
                m_led = pend[0].led;
                void'(pend.pop_front());
            end
            check("led", led, m_led);
            cyc++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic to_cycle(input int n);
        int g = 0;
        do begin
            @(posedge clk); #2;
            g++;
        end while (cyc < n && g < 50000);
        check("reach_cycle", cyc, n);
    endtask

    task automatic run_frames(input int n);
        for (int g = 0; g < 40000 && frames_done < n; g++) begin
            @(posedge clk); #2;
            if ($urandom_range(0, 19) == 0) dipsw = 4'($urandom_range(0, 3));
        end
        check("frame_progress", frames_done >= n, 1);
    endtask

    initial begin
        logic [7:0] ascii[$];
        for (int i = 0; i < 9; i++) ascii.push_back(8'(8'h31 + i));
        check("crc_model_check_value", crc32_bytes(ascii), 32'hCBF43926);

        rst   = 1'b0;
        dipsw = 4'h0;
        repeat (3) @(posedge clk);
        #2;
        check("hold_reset_txd", txd, 64'h0707070707070707);
        check("hold_reset_txc", txc, 8'hFF);
        check("hold_reset_led", led, 8'h00);
        @(posedge clk); #1 rst = 1'b1;

        // first frame, k=0
        to_cycle(16);
        check("w0_txd", txd, 64'hD5555555555555FB);
        check("w0_txc", txc, 8'h01);
        to_cycle(17);
        check("w1_txd", txd, 64'h1100FFFFFFFFFFFF);
        to_cycle(18);
        check("w2_txd_seq0", txd, 64'h0000B58855443322);
        to_cycle(25);
        check("fcs_txc_k0", txc, 8'hF0);
        check("fcs_term_k0", txd[63:32], 32'h070707FD);
        to_cycle(28);
        check("led_one_good", led, 8'h01);

        // second frame k=0, third frame k=1 with dipsw changed mid-frame
        to_cycle(43);
        check("led_two_good", led, 8'h02);
        dipsw = 4'h1;
        to_cycle(50);
        dipsw = 4'hF;
        to_cycle(61);
        check("fcs_txc_k1", txc, 8'hF0);
        to_cycle(64);
        check("led_three_good", led, 8'h03);
        to_cycle(100);
        dipsw = 4'h2;
        to_cycle(195);
        check("fcs_txc_k15", txc, 8'hF0);

        // random sizes, one corrupted frame (6) and one dropped frame (9)
        flip_frame = 6;
        flip_word  = int'($urandom_range(4, 8));
        flip_bit   = int'($urandom_range(0, 63));
        drop_frame = 9;
        run_frames(12);
        repeat (3) @(posedge clk);
        #2;
        check("led_after_faults", led, 8'h89);
        check("err_sticky", led[7], 1'b1);

        // reset in the middle of a frame
        for (int g = 0; g < 1000 && txc != 8'h00; g++) begin
            @(posedge clk); #2;
        end
        check("in_frame_before_reset", txc, 8'h00);
        rst = 1'b0;
        #1;
        check("abort_txd", txd, 64'h0707070707070707);
        check("abort_txc", txc, 8'hFF);
        check("abort_led", led, 8'h00);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        // after reset: drop frame 2, frame 3 then carries an unexpected seq
        flip_frame = -1;
        drop_frame = 2;
        run_frames(5);
        repeat (3) @(posedge clk);
        #2;
        check("led_after_drop", led, 8'h83);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/app.md
APP -- requirements
Module: app

Interface
REQ-001 SHALL have port xgmii_clk, input, 1 bit: the single clock, 156.25 MHz XGMII clock; all logic is clocked on its rising edge.
REQ-002 SHALL have port sys_rst, input, 1 bit: reset, asynchronous and active-low.
REQ-003 SHALL have port xgmii_txd, output, 64 bits: XGMII transmit data; lane n is bits [8n+7:8n], and lane 0 goes first on the wire.
REQ-004 SHALL have port xgmii_txc, output, 8 bits: XGMII transmit control, 1 bit per lane.
REQ-005 SHALL have port xgmii_rxd, input, 64 bits: XGMII receive data, same lane order as xgmii_txd.
REQ-006 SHALL have port xgmii_rxc, input, 8 bits: XGMII receive control.
REQ-007 SHALL have port dipsw, input, 4 bits: frame-size select k.
REQ-008 SHALL have port led, output, 8 bits: status display.
REQ-009 SHALL have parameter TX_START_DELAY, default 16: cycles from reset release to the first frame.
REQ-010 SHALL have parameter IFG_WORDS, default 4: idle words between frames.

Function
REQ-011 Idle word: SHALL be txd=0707070707070707h with txc=FFh.
REQ-012 Transmitter: SHALL output idle words for TX_START_DELAY cycles after reset release, then send frames back-to-back, separated by IFG_WORDS idle words.
REQ-013 dipsw SHALL be sampled as k on the cycle W0 is driven; changes mid-frame do not affect the current frame.
REQ-014 Word W0 SHALL be lanes0-7 = FB 55 55 55 55 55 55 D5, txc=01h.
REQ-015 Word W1 SHALL be dest MAC FF FF FF FF FF FF followed by src MAC bytes 00 11, txc=00h.
REQ-016 Word W2 SHALL be src MAC bytes 22 33 44 55, ethertype 88 B5, then seq[31:24] and seq[23:16], txc=00h.
REQ-017 Word W3 SHALL carry seq[15:8] and seq[7:0] in lanes 0-1 and 00h in lanes 2-7; every following payload word SHALL be all 00h, txc=00h.
REQ-018 Data words W1 through W(8(k+1)) SHALL total 64(k+1) bytes.
REQ-019 The FCS word SHALL carry the FCS in lanes 0-3, FD in lane 4 and 07 in lanes 5-7, with txc=F0h.
REQ-020 Total frame length SHALL be 64k+68 bytes.
REQ-021 FCS: IEEE 802.3 CRC-32; polynomial 04C11DB7h reflected, init FFFFFFFFh, final inversion; computed over W1 through the last data word; the LSB byte of the FCS goes in lane 0.
REQ-022 seq SHALL be 0 for the first frame after reset and increment by 1 per frame, wrapping at 2^32.
REQ-023 Receiver start: SHALL begin a frame only on rxc=01h with lane0=FBh; any other rxc is ignored outside a frame.
REQ-024 Receiver checks: ethertype = 88B5h; seq = expected (the first frame after reset loads expected); CRC over data words equals lanes 0-3 of the terminate word (rxc=F0h, lane4=FDh).
REQ-025 Receiver error cases: any control character inside the data words, or a missing terminate, SHALL count as an error and return the receiver to hunt.
REQ-026 Good frame: the good counter (32-bit, wrapping) SHALL increment on the cycle after the terminate word; expected seq becomes rx seq+1.
REQ-027 Bad frame: the sticky error flag SHALL be set; the good counter is unchanged; expected seq becomes rx seq+1.
REQ-028 LED mapping: led[7] = sticky error flag; led[6:0] = good counter[6:0]; led is registered.

Reset
REQ-029 While sys_rst=0, SHALL output idle on txd/txc and led=00h, with seq, counters, error flag and start delay cleared.
REQ-030 On assertion mid-frame, SHALL abort the frame immediately to idle (asynchronously); the receiver returns to hunt.

Structure
REQ-031 A shared package SHALL hold: XGMII constants (IDLE 07h, START FBh, TERM FDh, PREAMBLE word), MAC addresses, ethertype 88B5h, CRC polynomial/init.
REQ-032 There SHALL be one sub-module, crc32_d64: a combinational next-CRC over a 64-bit word, instantiated once in tx and once in rx.
REQ-033 The TX FSM SHALL have states WAIT, START, DATA, FCS, GAP; the RX FSM SHALL have states HUNT, DATA, CHECK.

Verification
REQ-034 Reset: hold sys_rst=0 -> txd=0707070707070707h, txc=FFh, led=00h.
REQ-035 Loopback with dipsw=0: first W0 16 cycles after release -> 8 data words, FCS word txc=F0h; then led=01h.
REQ-036 Loopback with dipsw=1 -> 16 data words (132-byte frame), 4 idle gap words, second frame seq=1 -> led=02h.
REQ-037 Change dipsw 0->F during frame -> current frame keeps k=0; the next frame has 128 data words.
REQ-038 Flip one rxd data bit in loopback -> led[7]=1 and stays 1; the good count does not increment for that frame.
REQ-039 Drop one whole frame on rx (force idle) -> the next frame has a seq mismatch -> led[7]=1.
